mux_drain_sequencer: RTL and testbench

Drains one output row of the transposed-convolution array through the 16-to-1 output mux and emits it as a valid/ready stream. The block drives the mux select, captures the selected word, and advances lane by lane under downstream backpressure. Between rows it handshakes with the upstream source bank so the next row can be presented, repeating for a configured row count. It sits directly downstream of the mux and upstream of the output writer/DMA.

---
 rtl/tconv_pkg.sv | 17 +
 rtl/drain_out_reg.sv | 64 ++++++
 rtl/mux_drain_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mux_drain_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tconv_pkg.sv
// Shared definitions for the transposed-convolution output drain path:
// FSM state encoding and lane-count constants.
package tconv_pkg;

    localparam int unsigned MAX_LANES   = 16;
    localparam int unsigned LANE_W      = 4;
    localparam int unsigned CFG_LANES_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_FLUSH    = 3'd4
    } state_e;

endpackage

// File: rtl/drain_out_reg.sv
// Single-entry output register for the drain stream.
// Holds data/valid/last while stalled; accept_c tells the producer a new
// word may be captured this cycle (register empty or being emptied).
//   clk, rst      : clock, synchronous active-high reset
//   cap_i         : capture data_i/last_i (only honoured when accept_c)
//   data_i/last_i : word and last flag to capture
//   ready_i       : downstream ready
//   accept_c      : combinational, register can take a word this cycle
//   data_o/valid_o/last_o : registered stream outputs
module drain_out_reg #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic                  ready_i,
    output logic                  accept_c,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  last_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;

    assign accept_c = !valid_q || ready_i;

    // Load on capture, drop valid once the held word is taken, else hold.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (accept_c) begin
            if (cap_i) begin
                data_d  = data_i;
                valid_d = 1'b1;
                last_d  = last_i;
            end else begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: rtl/mux_drain_sequencer.sv
// Drains output rows of the transposed-convolution array through the
// 16-to-1 output mux as a valid/ready stream, handshaking with the upstream
// source bank between rows.
// Build option: DRAIN_ROW_LAST_EN -- when defined, m_last marks the final
// lane of every row; otherwise only the final lane of the final row.
//   clk, rst            : clock, synchronous active-high reset
//   start               : job start pulse (ignored while busy)
//   cfg_lanes, cfg_rows : lanes per row (1..16), rows per job (>=1)
//   mux_sel, mux_data   : lane select to the mux and its data
//   row_req, row_ack    : next-row request pulse and upstream acknowledge
//   m_data/m_valid/m_ready/m_last : output stream
//   busy, done          : job active, job completion pulse
module mux_drain_sequencer
    import tconv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ROW_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CFG_LANES_W-1:0] cfg_lanes,
    input  logic [ROW_W-1:0]       cfg_rows,
    output logic [LANE_W-1:0]      mux_sel,
    input  logic [DATA_WIDTH-1:0]  mux_data,
    output logic                   row_req,
    input  logic                   row_ack,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done
);

`ifdef DRAIN_ROW_LAST_EN
    localparam bit ROW_LAST_EN = 1'b1;
`else
    localparam bit ROW_LAST_EN = 1'b0;
`endif

    state_e                 state_q, state_d;
    logic [CFG_LANES_W-1:0] lanes_q, lanes_d;
    logic [ROW_W-1:0]       rows_q, rows_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [ROW_W-1:0]       row_cnt_q, row_cnt_d;
    logic [LANE_W-1:0]      mux_sel_q, mux_sel_d;
    logic                   row_req_q, row_req_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic cap_c;
    logic beat_last_c;
    logic accept_c;
    logic cfg_legal_c;
    logic final_lane_c;
    logic last_row_c;

    assign cfg_legal_c  = (cfg_lanes != '0)
                       && (cfg_lanes <= CFG_LANES_W'(MAX_LANES))
                       && (cfg_rows != '0);
    assign final_lane_c = ({1'b0, lane_q} == (lanes_q - CFG_LANES_W'(1)));
    assign last_row_c   = (ROW_W'(row_cnt_q + ROW_W'(1)) == rows_q);

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d     = state_q;
        lanes_d     = lanes_q;
        rows_d      = rows_q;
        lane_d      = lane_q;
        row_cnt_d   = row_cnt_q;
        done_d      = 1'b0;
        cap_c       = 1'b0;
        beat_last_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_legal_c) begin
                        lanes_d   = cfg_lanes;
                        rows_d    = cfg_rows;
                        lane_d    = '0;
                        row_cnt_d = '0;
                        state_d   = ST_REQ;
                    end else begin
                        // Degenerate job: complete immediately, no traffic.
                        done_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                state_d = row_ack ? ST_DRAIN : ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (row_ack) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (accept_c) begin
                    cap_c = 1'b1;
                    if (final_lane_c) begin
                        lane_d      = '0;
                        row_cnt_d   = ROW_W'(row_cnt_q + ROW_W'(1));
                        beat_last_c = ROW_LAST_EN || last_row_c;
                        state_d     = last_row_c ? ST_FLUSH : ST_REQ;
                    end else begin
                        lane_d = LANE_W'(lane_q + LANE_W'(1));
                    end
                end
            end
            ST_FLUSH: begin
                // Final beat is already registered; wait for it to leave.
                if (m_valid && m_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        row_req_d = (state_d == ST_REQ);
        busy_d    = (state_d != ST_IDLE);
        mux_sel_d = (state_d == ST_DRAIN) ? lane_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lanes_q   <= '0;
            rows_q    <= '0;
            lane_q    <= '0;
            row_cnt_q <= '0;
            mux_sel_q <= '0;
            row_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lanes_q   <= lanes_d;
            rows_q    <= rows_d;
            lane_q    <= lane_d;
            row_cnt_q <= row_cnt_d;
            mux_sel_q <= mux_sel_d;
            row_req_q <= row_req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    drain_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .cap_i    (cap_c),
        .data_i   (mux_data),
        .last_i   (beat_last_c),
        .ready_i  (m_ready),
        .accept_c (accept_c),
        .data_o   (m_data),
        .valid_o  (m_valid),
        .last_o   (m_last)
    );

    assign mux_sel = mux_sel_q;
    assign row_req = row_req_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mux_drain_sequencer.sv
// Bench for mux_drain_sequencer: upstream mux/row-source model, scoreboard
// of expected beats built from the job configuration, and directed tests.
module tb_mux_drain_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 16;

`ifdef DRAIN_ROW_LAST_EN
    localparam bit ROW_LAST = 1'b1;
`else
    localparam bit ROW_LAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    cfg_lanes;
    logic [RW-1:0] cfg_rows;
    logic [3:0]    mux_sel;
    logic [DW-1:0] mux_data;
    logic          row_req;
    logic          row_ack;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_last;
    logic          busy;
    logic          done;

    mux_drain_sequencer #(.DATA_WIDTH(DW), .ROW_W(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_lanes (cfg_lanes),
        .cfg_rows  (cfg_rows),
        .mux_sel   (mux_sel),
        .mux_data  (mux_data),
        .row_req   (row_req),
        .row_ack   (row_ack),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];

    int total = 0;
    int bad   = 0;

    logic [3:0]    salt = 4'h0;
    int            row_seen = 0;
    int            ack_delay = 0;
    logic          ack_pulse = 1'b0;
    int            ready_mode = 0;
    int            req_cnt = 0;
    int            done_cnt = 0;
    int            last_cnt = 0;
    logic [DW-1:0] last_hs_data = '0;

    // Upstream: word = {job salt, row number (1-based), 0, lane}.
    assign mux_data = {salt, 4'(row_seen), 4'h0, mux_sel};
    assign row_ack  = (ack_delay == 0) | ack_pulse;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row source: count requests and present the next row's data.
    always @(negedge clk) begin
        if (!rst) begin
            if (row_req) begin
                req_cnt++;
                row_seen++;
            end
            if (done) done_cnt++;
        end
    end

    // Delayed row acknowledge pulse.
    always @(negedge clk) begin
        if (!rst && row_req && ack_delay != 0) begin
            repeat (ack_delay) @(posedge clk);
            #1 ack_pulse = 1'b1;
            @(posedge clk);
            #1 ack_pulse = 1'b0;
        end
    end

    // Downstream ready pattern.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    // Compare process: scoreboard on every handshake, stability while stalled.
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic          prev_rst   = 1'b1;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    always @(negedge clk) begin
        if (!rst && !prev_rst && prev_valid && !prev_ready) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", 32'(m_data), 32'(prev_data));
            check("stall_last", 32'(m_last), 32'(prev_last));
        end
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat: got data 0x%0h with no beat expected at %0t", m_data, $time);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check("beat_data", 32'(m_data), 32'(b.data));
                check("beat_last", 32'(m_last), 32'(b.last));
            end
            last_hs_data = m_data;
            if (m_last) last_cnt++;
        end
        if (!rst && done) check("done_busy_low", 32'(busy), 32'd0);
        prev_valid = m_valid;
        prev_ready = m_ready;
        prev_rst   = rst;
        prev_data  = m_data;
        prev_last  = m_last;
    end

    // Start a job; push the expected beat sequence when the config is legal.
    task automatic start_job(input int lanes, input int rows, input logic [3:0] s);
        salt     = s;
        row_seen = 0;
        req_cnt  = 0;
        done_cnt = 0;
        last_cnt = 0;
        if (lanes >= 1 && lanes <= 16 && rows >= 1) begin
            for (int r = 0; r < rows; r++) begin
                for (int l = 0; l < lanes; l++) begin
                    beat_t b;
                    b.data = {s, 4'(r + 1), 4'h0, 4'(l)};
                    b.last = (l == lanes - 1) && (ROW_LAST || r == rows - 1);
                    exp_q.push_back(b);
                end
            end
        end
        cfg_lanes = 5'(lanes);
        cfg_rows  = RW'(rows);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input int exp_rows);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_done"}, 32'(done_cnt), 32'd1);
        check({name, "_rowreq"}, 32'(req_cnt), 32'(exp_rows));
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cfg_lanes = '0;
        cfg_rows  = '0;
        repeat (3) tick();
        check("rst_mux_sel", 32'(mux_sel), 32'd0);
        check("rst_row_req", 32'(row_req), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // Full 16-lane row, ack tied high, ready high: cycle-exact pins.
        ack_delay  = 0;
        ready_mode = 0;
        start_job(16, 1, 4'h0);
        check("t1_c1_busy", 32'(busy), 32'd1);
        check("t1_c1_row_req", 32'(row_req), 32'd1);
        tick();
        check("t1_c2_mux_sel", 32'(mux_sel), 32'd0);
        check("t1_c2_m_valid", 32'(m_valid), 32'd0);
        tick();
        check("t1_c3_m_valid", 32'(m_valid), 32'd1);
        check("t1_c3_m_data", 32'(m_data), 32'h0100);
        repeat (15) tick();
        check("t1_c18_m_data", 32'(m_data), 32'h010F);
        check("t1_c18_m_last", 32'(m_last), 32'd1);
        tick();
        check("t1_c19_done", 32'(done), 32'd1);
        check("t1_c19_busy", 32'(busy), 32'd0);
        wait_done("t1", 10, 1);

        // Three rows of four lanes, ack delayed five cycles per row.
        ack_delay = 5;
        start_job(4, 3, 4'h2);
        wait_done("t2", 200, 3);
        check("t2_final_word", 32'(last_hs_data), 32'h2303);
        check("t2_last_count", 32'(last_cnt), ROW_LAST ? 32'd3 : 32'd1);

        // Pseudo-random backpressure.
        ack_delay  = 2;
        ready_mode = 1;
        start_job(5, 4, 4'h6);
        wait_done("t3", 600, 4);
        ready_mode = 0;
        tick();

        // Illegal configurations: immediate done, no traffic.
        ack_delay = 0;
        start_job(0, 2, 4'h7);
        check("t4a_done", 32'(done), 32'd1);
        check("t4a_busy", 32'(busy), 32'd0);
        tick();
        check("t4a_done_clr", 32'(done), 32'd0);
        check("t4a_m_valid", 32'(m_valid), 32'd0);
        start_job(3, 0, 4'h7);
        check("t4b_done", 32'(done), 32'd1);
        repeat (3) tick();
        check("t4b_m_valid", 32'(m_valid), 32'd0);
        start_job(17, 1, 4'h7);
        check("t4c_done", 32'(done), 32'd1);
        repeat (3) tick();
        check("t4c_rowreq", 32'(req_cnt), 32'd0);
        check("t4c_busy", 32'(busy), 32'd0);

        // Reset mid-row with a stalled beat, then replay.
        ready_mode = 2;
        tick();
        start_job(8, 2, 4'h3);
        repeat (4) tick();
        check("t5_stalled_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("t5_rst_m_valid", 32'(m_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_mux_sel", 32'(mux_sel), 32'd0);
        rst        = 1'b0;
        ready_mode = 0;
        tick();
        start_job(8, 2, 4'h4);
        wait_done("t5", 100, 2);

        // start during DRAIN with a different config is ignored.
        ack_delay = 3;
        start_job(6, 2, 4'h5);
        repeat (6) tick();
        cfg_lanes = 5'd3;
        cfg_rows  = RW'(1);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("t6_still_busy", 32'(busy), 32'd1);
        wait_done("t6", 200, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
